// File: rtl/cpu_sim_pkg.sv
// Shared types for the cpu simulation monitor: FSM states, FIFO entry layout
// and the cycle-stamp width.
package cpu_sim_pkg;

    localparam int unsigned CYCLE_W    = 16;
    localparam int unsigned MON_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic [MON_DATA_W-1:0] addr;
        logic [MON_DATA_W-1:0] data;
        logic [CYCLE_W-1:0]    cycle;
    } mon_entry_t;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Bus between the core/bench side and cpu_run_monitor.
//   master: drives pc, data-memory store port and rd_en; observes FIFO and status.
//   slave : the monitor itself.
interface cpu_run_monitor_if
    import cpu_sim_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]  pc;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               rd_en;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic [CYCLE_W-1:0] rd_cycle;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               halted;
    logic               timeout;
    logic               done;
    logic [CYCLE_W-1:0] cycle_count;

    modport master (
        output pc, dmem_we, dmem_addr, dmem_wdata, rd_en,
        input  rd_valid, rd_addr, rd_data, rd_cycle, count,
               overflow, halted, timeout, done, cycle_count
    );

    modport slave (
        input  pc, dmem_we, dmem_addr, dmem_wdata, rd_en,
        output rd_valid, rd_addr, rd_data, rd_cycle, count,
               overflow, halted, timeout, done, cycle_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head output.
//   clk, reset : clock, synchronous active-high reset
//   push_i/din_i : write request and data (dropped when full unless popping)
//   pop_i        : remove head entry (ignored when empty)
//   dout_o       : head entry, zero when empty
//   full_o, empty_o, count_o : occupancy status
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = dout_q;
    assign count_o = count_q;

    // Accept/pointer/occupancy update and next head selection.
    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The entry being written this edge bypasses storage when it becomes head.
        if (count_d == '0) begin
            dout_d = '0;
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            dout_d = din_i;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for the cpu core: logs data-memory stores with a cycle stamp into
// a FIFO and detects completion (branch-to-self halt) or a cycle-budget timeout.
//   clk, reset : core clock, synchronous active-high reset
//   mon        : slave side of cpu_run_monitor_if (pc, store port, FIFO read
//                port, count/overflow/halted/timeout/done/cycle_count status)
module cpu_run_monitor
    import cpu_sim_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 8,
    parameter int unsigned MAX_CYCLES  = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_monitor_if.slave     mon
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned STABLE_W = $clog2(HALT_CYCLES + 1);
    localparam int unsigned ENTRY_W  = $bits(mon_entry_t);

    mon_state_e          state_q, state_d;
    logic [DATA_W-1:0]   pc_q;
    logic                pc_valid_q;
    logic [STABLE_W-1:0] stable_q, stable_d;
    logic [CYCLE_W-1:0]  cycle_q, cycle_d;
    logic                overflow_q, overflow_d;
    logic                halted_q;
    logic                timeout_q;
    logic                done_q;

    logic                pc_eq;
    logic                halt_hit;
    logic                budget_hit;
    logic                push_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_dout;
    mon_entry_t          push_entry;
    mon_entry_t          head_entry;

    // Next-state, halt detection, cycle counting and capture decision.
    always_comb begin
        state_d    = state_q;
        stable_d   = '0;
        cycle_d    = cycle_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;

        // pc_q holds nothing meaningful on the first cycle out of reset.
        pc_eq      = pc_valid_q && (mon.pc == pc_q);
        halt_hit   = pc_eq && (stable_q == STABLE_W'(HALT_CYCLES - 1));
        budget_hit = (cycle_q == CYCLE_W'(MAX_CYCLES - 1));

        if (pc_eq) begin
            stable_d = (stable_q == STABLE_W'(HALT_CYCLES)) ? stable_q
                                                            : stable_q + STABLE_W'(1);
        end

        unique case (state_q)
            ST_RUN: begin
                push_req = mon.dmem_we;
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + CYCLE_W'(1);
                end
                // Halt takes priority when both fire on the same cycle.
                if (halt_hit) begin
                    state_d = ST_HALTED;
                end else if (budget_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A same-cycle pop frees the slot, so only a pop-less push at full drops.
        if (push_req && fifo_full && !mon.rd_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            stable_q   <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= mon.pc;
            pc_valid_q <= 1'b1;
            stable_q   <= stable_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            halted_q   <= (state_d == ST_HALTED);
            timeout_q  <= (state_d == ST_TIMEOUT);
            done_q     <= (state_d != ST_RUN);
        end
    end

    // Store record: address, data and the stamp of the cycle it occurred in.
    always_comb begin
        push_entry.addr  = MON_DATA_W'(mon.dmem_addr);
        push_entry.data  = MON_DATA_W'(mon.dmem_wdata);
        push_entry.cycle = cycle_q;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .din_i   (push_entry),
        .pop_i   (mon.rd_en),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_entry      = mon_entry_t'(fifo_dout);
    assign mon.rd_valid    = ~fifo_empty;
    assign mon.rd_addr     = DATA_W'(head_entry.addr);
    assign mon.rd_data     = DATA_W'(head_entry.data);
    assign mon.rd_cycle    = head_entry.cycle;
    assign mon.count       = fifo_count;
    assign mon.overflow    = overflow_q;
    assign mon.halted      = halted_q;
    assign mon.timeout     = timeout_q;
    assign mon.done        = done_q;
    assign mon.cycle_count = cycle_q;

endmodule
